// File: rtl/arb_pkg.sv
// Shared definitions for the 3-channel arbiter and its downstream grant stage.
package arb_pkg;

  localparam int NCH = 3;

  typedef logic [1:0] ch_id_t;

  // Index of the set bit in a one-hot channel vector; 0 for an all-zero vector.
  function automatic ch_id_t onehot_to_idx(input logic [2:0] v);
    ch_id_t idx;
    idx = 2'd0;
    case (v)
      3'b010:  idx = 2'd1;
      3'b100:  idx = 2'd2;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // True when the vector has at most one bit set.
  function automatic bit is_onehot0(input logic [2:0] v);
    return (v & (v - 3'd1)) == 3'b000;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with the head entry read straight out of the storage
// registers, so valid/head/count never depend combinationally on push or pop.
// The caller must not push when full nor pop when empty.
module sync_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic                   valid,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_ONE = 1;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [W-1:0]  mem [DEPTH];

  // Pointers, occupancy and storage; storage is cleared so the head reads 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  assign valid = (count != '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/arb_grant_stage.sv
// Consumer side of the 3-channel round-robin arbiter. Requests are only
// forwarded while the output FIFO has room; a legal grant accepts that
// channel's payload in the same cycle and queues it with its channel id.
//
// Handshakes: a channel transfer happens in a cycle where ch_valid[i] and
// ch_ready[i] are both high; an output transfer happens in a cycle where
// out_valid and out_ready are both high. ch_valid must not depend on ch_ready.
module arb_grant_stage
  import arb_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 2,
  parameter int CW    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        ch_valid,
  input  logic [3*DW-1:0]   ch_data,
  output logic [2:0]        ch_ready,
  output logic [2:0]        arb_req,
  input  logic [2:0]        arb_grant,
  output logic              out_valid,
  output logic [DW-1:0]     out_data,
  output logic [1:0]        out_ch,
  input  logic              out_ready,
  input  logic              cnt_clr,
  output logic [3*CW-1:0]   grant_cnt,
  output logic              grant_err
);

  localparam int CNTW = $clog2(DEPTH) + 1;

  logic [CNTW-1:0] count;
  logic            space;
  logic            grant_legal;
  logic            push;
  logic            pop;
  ch_id_t          push_idx;
  logic [DW-1:0]   sel_data;
  logic [DW+1:0]   head;
  logic [CW-1:0]   cnt_q [NCH];

  // Space is judged on the registered count only, so a pop in a full cycle
  // does not reopen requests until the following cycle.
  assign space   = (count < CNTW'(DEPTH));
  assign arb_req = ch_valid & {NCH{space}};

  // A grant is legal when empty or one-hot inside the current request vector.
  assign grant_legal = is_onehot0(arb_grant) && ((arb_grant & ~arb_req) == 3'b000);
  assign push        = grant_legal && (arb_grant != 3'b000);
  assign ch_ready    = push ? arb_grant : 3'b000;
  assign push_idx    = onehot_to_idx(arb_grant);
  assign pop         = out_valid & out_ready;

  // Select the granted channel's payload.
  always_comb begin
    sel_data = ch_data[DW-1:0];
    case (push_idx)
      2'd1:    sel_data = ch_data[2*DW-1:DW];
      2'd2:    sel_data = ch_data[3*DW-1:2*DW];
      default: sel_data = ch_data[DW-1:0];
    endcase
  end

  sync_fifo #(
    .W     (DW + 2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({push_idx, sel_data}),
    .pop       (pop),
    .valid     (out_valid),
    .head      (head),
    .count     (count)
  );

  assign out_ch   = head[DW+1:DW];
  assign out_data = head[DW-1:0];

  // Per-channel accepted-transfer counters; clear wins over a coincident push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (cnt_clr)
          cnt_q[i] <= '0;
        else if (push && arb_grant[i] && (cnt_q[i] != {CW{1'b1}}))
          cnt_q[i] <= cnt_q[i] + CW'(1);
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_cnt_out
    assign grant_cnt[g*CW +: CW] = cnt_q[g];
  end

  // Sticky flag for any non-zero grant that is not legal; cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      grant_err <= 1'b0;
    else if ((arb_grant != 3'b000) && !grant_legal)
      grant_err <= 1'b1;
  end

endmodule

// File: tb/tb_arb_grant_stage.sv
// Bench for arb_grant_stage: round-robin arbiter model, scoreboard monitor,
// a table of single-cycle vectors and hand-written multi-cycle sequences.
module tb_arb_grant_stage;

  localparam int DW    = 8;
  localparam int DEPTH = 2;
  localparam int CW    = 2;

  logic            clk;
  logic            rst_n;
  logic [2:0]      ch_valid;
  logic [3*DW-1:0] ch_data;
  logic [2:0]      ch_ready;
  logic [2:0]      arb_req;
  logic [2:0]      arb_grant;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_ch;
  logic            out_ready;
  logic            cnt_clr;
  logic [3*CW-1:0] grant_cnt;
  logic            grant_err;

  int checks   = 0;
  int failures = 0;

  arb_grant_stage #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ch_valid  (ch_valid),
    .ch_data   (ch_data),
    .ch_ready  (ch_ready),
    .arb_req   (arb_req),
    .arb_grant (arb_grant),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready),
    .cnt_clr   (cnt_clr),
    .grant_cnt (grant_cnt),
    .grant_err (grant_err)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- arbiter model ----------------
  logic       force_mode;
  logic [2:0] force_grant;
  int         rr_last;

  always_comb begin
    arb_grant = 3'b000;
    if (force_mode) begin
      arb_grant = force_grant;
    end else begin
      for (int k = 1; k <= 3; k++) begin
        if (arb_grant == 3'b000 && arb_req[(rr_last + k) % 3])
          arb_grant = 3'b001 << ((rr_last + k) % 3);
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_last <= 2;
    else if (!force_mode && arb_grant != 3'b000)
      rr_last <= arb_grant[2] ? 2 : (arb_grant[1] ? 1 : 0);
  end

  // ---------------- scoreboard monitor ----------------
  logic [DW+1:0] exp_q[$];
  int            model_cnt;
  logic          model_err;
  int            model_gcnt [3];
  logic [2:0]    e_req;
  logic [2:0]    e_ready;
  logic          e_legal;
  logic          e_push;
  logic          e_pop;
  logic [1:0]    e_idx;
  logic [DW+1:0] e_head;

  always @(negedge clk) begin
    if (!rst_n) begin
      model_cnt = 0;
      model_err = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 3; i++) model_gcnt[i] = 0;
    end else begin
      e_req   = ch_valid & ((model_cnt < DEPTH) ? 3'b111 : 3'b000);
      e_legal = (arb_grant == 3'b000) ||
                (($countones(arb_grant) == 1) && ((arb_grant & ~e_req) == 3'b000));
      e_push  = e_legal && (arb_grant != 3'b000);
      e_ready = e_push ? arb_grant : 3'b000;
      check("mon_arb_req", 32'(arb_req), 32'(e_req));
      check("mon_ch_ready", 32'(ch_ready), 32'(e_ready));
      check("mon_out_valid", 32'(out_valid), 32'(model_cnt != 0));
      check("mon_grant_err", 32'(grant_err), 32'(model_err));
      for (int i = 0; i < 3; i++)
        check($sformatf("mon_grant_cnt%0d", i), 32'(grant_cnt[i*CW +: CW]), 32'(model_gcnt[i]));
      e_pop = (model_cnt != 0) && out_ready;
      if (e_pop && exp_q.size() > 0) begin
        e_head = exp_q.pop_front();
        check("mon_out_data", 32'(out_data), 32'(e_head[DW-1:0]));
        check("mon_out_ch", 32'(out_ch), 32'(e_head[DW+1:DW]));
      end
      if (e_push) begin
        e_idx = arb_grant[2] ? 2'd2 : (arb_grant[1] ? 2'd1 : 2'd0);
        exp_q.push_back({e_idx, ch_data[int'(e_idx)*DW +: DW]});
      end
      for (int i = 0; i < 3; i++) begin
        if (cnt_clr) model_gcnt[i] = 0;
        else if (e_push && arb_grant[i] && model_gcnt[i] < (1 << CW) - 1) model_gcnt[i]++;
      end
      if (arb_grant != 3'b000 && !e_legal) model_err = 1'b1;
      model_cnt = model_cnt + (e_push ? 1 : 0) - (e_pop ? 1 : 0);
    end
  end

  // ---------------- driver helpers ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    ch_data = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
  endtask

  task automatic idle(input int n);
    ch_valid   = 3'b000;
    force_mode = 1'b1;
    force_grant = 3'b000;
    cnt_clr    = 1'b0;
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  task automatic drain();
    out_ready = 1'b1;
    idle(3);
    out_ready = 1'b0;
  endtask

  task automatic clear_counters();
    ch_valid = 3'b000;
    force_mode = 1'b1;
    force_grant = 3'b000;
    cnt_clr = 1'b1;
    next_cycle();
    cnt_clr = 1'b0;
  endtask

  function automatic logic [CW-1:0] gc(input int i);
    return grant_cnt[i*CW +: CW];
  endfunction

  typedef struct {
    logic [2:0] valid;
    logic [2:0] grant;
    logic [2:0] exp_req;
    logic [2:0] exp_ready;
  } vec_t;

  vec_t vecs [8];
  int   push_seen;
  logic [1:0] rr_seq [6];

  // ---------------- stimulus ----------------
  initial begin
    vecs[0] = '{3'b000, 3'b000, 3'b000, 3'b000};
    vecs[1] = '{3'b001, 3'b001, 3'b001, 3'b001};
    vecs[2] = '{3'b100, 3'b100, 3'b100, 3'b100};
    vecs[3] = '{3'b111, 3'b010, 3'b111, 3'b010};
    vecs[4] = '{3'b110, 3'b000, 3'b110, 3'b000};
    vecs[5] = '{3'b011, 3'b001, 3'b011, 3'b001};
    vecs[6] = '{3'b101, 3'b100, 3'b101, 3'b100};
    vecs[7] = '{3'b000, 3'b000, 3'b000, 3'b000};
    rr_seq = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};

    rst_n = 1'b0;
    ch_valid = 3'b000;
    ch_data = '0;
    out_ready = 1'b0;
    cnt_clr = 1'b0;
    force_mode = 1'b1;
    force_grant = 3'b000;

    // Reset values.
    #3;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_ch", 32'(out_ch), 0);
    check("rst_grant_cnt", 32'(grant_cnt), 0);
    check("rst_grant_err", 32'(grant_err), 0);
    check("rst_arb_req", 32'(arb_req), 0);
    check("rst_ch_ready", 32'(ch_ready), 0);
    #19 rst_n = 1'b1;
    next_cycle();

    // Table of single-cycle vectors; output drains every cycle so space stays open.
    out_ready = 1'b1;
    for (int v = 0; v < 8; v++) begin
      ch_valid = vecs[v].valid;
      force_grant = vecs[v].grant;
      rand_data();
      @(negedge clk);
      check($sformatf("vec%0d_arb_req", v), 32'(arb_req), 32'(vecs[v].exp_req));
      check($sformatf("vec%0d_ch_ready", v), 32'(ch_ready), 32'(vecs[v].exp_ready));
      next_cycle();
    end
    drain();
    clear_counters();

    // Single channel with same-cycle acceptance and one-cycle output latency.
    ch_valid = 3'b010;
    ch_data = {8'h11, 8'hA5, 8'h22};
    force_grant = 3'b010;
    @(negedge clk);
    check("single_ch_ready", 32'(ch_ready), 32'h2);
    next_cycle();
    ch_valid = 3'b000;
    force_grant = 3'b000;
    @(negedge clk);
    check("single_out_valid", 32'(out_valid), 1);
    check("single_out_data", 32'(out_data), 32'hA5);
    check("single_out_ch", 32'(out_ch), 1);
    check("single_grant_cnt1", 32'(gc(1)), 1);
    next_cycle();
    drain();
    clear_counters();

    // Round-robin, all channels valid, sustained throughput.
    force_mode = 1'b0;
    ch_valid = 3'b111;
    out_ready = 1'b1;
    rand_data();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("rr_out_valid", 32'(out_valid), 1);
        check("rr_out_ch", 32'(out_ch), 32'(rr_seq[i-1]));
      end
      next_cycle();
      rand_data();
    end
    ch_valid = 3'b000;
    @(negedge clk);
    check("rr_out_valid_last", 32'(out_valid), 1);
    check("rr_out_ch_last", 32'(out_ch), 32'(rr_seq[5]));
    for (int i = 0; i < 3; i++) check($sformatf("rr_grant_cnt%0d", i), 32'(gc(i)), 2);
    next_cycle();
    drain();

    // Backpressure: exactly DEPTH pushes, then requests close until after a pop.
    force_mode = 1'b0;
    ch_valid = 3'b111;
    out_ready = 1'b0;
    push_seen = 0;
    for (int i = 0; i < 4; i++) begin
      rand_data();
      @(negedge clk);
      if (ch_ready != 3'b000) push_seen++;
      next_cycle();
    end
    check("bp_push_count", 32'(push_seen), DEPTH);
    @(negedge clk);
    check("bp_full_arb_req", 32'(arb_req), 0);
    check("bp_full_ch_ready", 32'(ch_ready), 0);
    next_cycle();
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_pop_cycle_arb_req", 32'(arb_req), 0);
    next_cycle();
    out_ready = 1'b0;
    @(negedge clk);
    check("bp_resume_arb_req", 32'(arb_req), 32'h7);
    next_cycle();
    drain();

    // Illegal grants: multi-hot, then a grant outside the request vector.
    force_mode = 1'b1;
    ch_valid = 3'b011;
    force_grant = 3'b011;
    @(negedge clk);
    check("ill1_ch_ready", 32'(ch_ready), 0);
    next_cycle();
    ch_valid = 3'b000;
    force_grant = 3'b000;
    @(negedge clk);
    check("ill1_no_push", 32'(out_valid), 0);
    check("ill1_grant_err", 32'(grant_err), 1);
    next_cycle();
    ch_valid = 3'b001;
    force_grant = 3'b100;
    @(negedge clk);
    check("ill2_arb_req", 32'(arb_req), 1);
    check("ill2_ch_ready", 32'(ch_ready), 0);
    next_cycle();
    ch_valid = 3'b000;
    force_grant = 3'b000;
    idle(2);
    @(negedge clk);
    check("ill2_no_push", 32'(out_valid), 0);
    check("ill_grant_err_sticky", 32'(grant_err), 1);
    next_cycle();
    clear_counters();

    // Counter saturation, then clear coinciding with a push.
    force_mode = 1'b0;
    out_ready = 1'b1;
    ch_valid = 3'b001;
    for (int i = 0; i < 5; i++) begin
      rand_data();
      next_cycle();
    end
    ch_valid = 3'b000;
    @(negedge clk);
    check("sat_grant_cnt0", 32'(gc(0)), 3);
    next_cycle();
    ch_valid = 3'b001;
    cnt_clr = 1'b1;
    @(negedge clk);
    check("clr_push_ch_ready", 32'(ch_ready), 1);
    next_cycle();
    ch_valid = 3'b000;
    cnt_clr = 1'b0;
    @(negedge clk);
    check("clr_push_grant_cnt0", 32'(gc(0)), 0);
    next_cycle();
    drain();

    // Asynchronous reset with a full FIFO.
    force_mode = 1'b0;
    ch_valid = 3'b111;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      next_cycle();
    end
    ch_valid = 3'b000;
    @(negedge clk);
    check("pre_rst_out_valid", 32'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 0);
    check("arst_grant_cnt", 32'(grant_cnt), 0);
    check("arst_grant_err", 32'(grant_err), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    next_cycle();
    force_mode = 1'b1;
    ch_valid = 3'b100;
    ch_data = {8'h3C, 8'h00, 8'h00};
    force_grant = 3'b100;
    @(negedge clk);
    check("post_rst_ch_ready", 32'(ch_ready), 32'h4);
    next_cycle();
    ch_valid = 3'b000;
    force_grant = 3'b000;
    @(negedge clk);
    check("post_rst_out_valid", 32'(out_valid), 1);
    check("post_rst_out_data", 32'(out_data), 32'h3C);
    check("post_rst_out_ch", 32'(out_ch), 2);
    check("post_rst_grant_cnt2", 32'(gc(2)), 1);
    next_cycle();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
